// File: rtl/i2c_multi_arb.sv
// Multi-master I2C bus combiner: wired-AND bus lines, bitwise arbitration,
// single-address match and byte capture with abort/error reporting.
module i2c_multi_arb #(
  parameter int                NUM_M      = 2,
  parameter int                ADDR_W     = 7,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] SLAVE_ADDR = 7'b1010101,
  parameter int                PRIO_MODE  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_M-1:0]  sda_in,
  input  logic [NUM_M-1:0]  scl_in,
  output logic              scl,
  output logic              sda,
  output logic [NUM_M-1:0]  grant,
  output logic [NUM_M-1:0]  lost,
  output logic              busy,
  output logic [ADDR_W-1:0] addr_out,
  output logic              rw_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              addr_err,
  output logic              abort
);
  localparam int IDX_W = $clog2(NUM_M);
  localparam int CNT_W = $clog2(((ADDR_W > DATA_W) ? ADDR_W : DATA_W) + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_DATA, S_DATA_ACK, S_WAIT_STOP
  } state_t;

  state_t             r_state;
  logic [NUM_M-1:0]   r_mask;
  logic [CNT_W-1:0]   r_cnt;
  logic [ADDR_W:0]    r_addr_sr;
  logic [DATA_W-2:0]  r_data_sr;
  logic [IDX_W-1:0]   r_last;
  logic               r_scl_q;
  logic               r_sda_q;

  logic               w_rise;
  logic               w_start;
  logic               w_stop;
  logic [NUM_M-1:0]   w_lose;
  logic [DATA_W-1:0]  w_byte;
  logic [NUM_M-1:0]   w_pick;
  logic               w_found;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_mask_idx;

  assign scl     = &(scl_in | ~r_mask);
  assign sda     = &(sda_in | ~r_mask);
  assign w_rise  = scl & ~r_scl_q;
  assign w_start = scl & r_scl_q & r_sda_q & ~sda;
  assign w_stop  = scl & r_scl_q & ~r_sda_q & sda;
  assign w_lose  = r_mask & sda_in & {NUM_M{~sda}};
  assign w_byte  = {r_data_sr, sda};
  assign grant   = r_mask;

  // Tie winner search: fixed order from 0, or rotating from one past the last winner.
  always_comb begin
    w_pick     = '0;
    w_found    = 1'b0;
    w_idx      = '0;
    w_mask_idx = '0;
    for (int unsigned k = 0; k < NUM_M; k++) begin
      if (PRIO_MODE == 0) w_idx = IDX_W'(k);
      else                w_idx = IDX_W'((32'(r_last) + k + 1) % NUM_M);
      if (!w_found && r_mask[w_idx]) begin
        w_found       = 1'b1;
        w_pick[w_idx] = 1'b1;
      end
      if (r_mask[IDX_W'(k)]) w_mask_idx = IDX_W'(k);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_mask     <= '1;
      r_cnt      <= '0;
      r_addr_sr  <= '0;
      r_data_sr  <= '0;
      r_last     <= IDX_W'(NUM_M - 1);
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
      busy       <= 1'b0;
      lost       <= '0;
      addr_out   <= '0;
      rw_out     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      addr_err   <= 1'b0;
      abort      <= 1'b0;
    end else begin
      r_scl_q    <= scl;
      r_sda_q    <= sda;
      lost       <= '0;
      data_valid <= 1'b0;
      addr_err   <= 1'b0;
      abort      <= 1'b0;
      // STOP/START override the per-state edge handling; WAIT_STOP only honours STOP.
      if (r_state != S_IDLE && w_stop) begin
        r_state <= S_IDLE;
        busy    <= 1'b0;
        r_mask  <= '1;
        if (r_state == S_ADDR || (r_state == S_DATA && r_cnt != CNT_W'(DATA_W - 1)))
          abort <= 1'b1;
        if ($onehot(r_mask)) r_last <= w_mask_idx;
      end else if (r_state != S_IDLE && r_state != S_WAIT_STOP && w_start) begin
        r_state <= S_ADDR;
        r_cnt   <= CNT_W'(ADDR_W);
      end else begin
        case (r_state)
          S_IDLE: if (w_start) begin
            r_mask  <= ~sda_in;
            busy    <= 1'b1;
            r_cnt   <= CNT_W'(ADDR_W);
            r_state <= S_ADDR;
          end
          S_ADDR: if (w_rise) begin
            r_addr_sr <= {r_addr_sr[ADDR_W-1:0], sda};
            r_mask    <= r_mask & ~w_lose;
            lost      <= w_lose;
            if (r_cnt == '0) r_state <= S_ADDR_ACK;
            else             r_cnt   <= r_cnt - 1'b1;
          end
          S_ADDR_ACK: if (w_rise) begin
            if (r_addr_sr[ADDR_W:1] == SLAVE_ADDR) begin
              addr_out <= r_addr_sr[ADDR_W:1];
              rw_out   <= r_addr_sr[0];
              r_cnt    <= CNT_W'(DATA_W - 1);
              r_state  <= S_DATA;
              if (!$onehot0(r_mask)) begin
                r_mask <= w_pick;
                lost   <= r_mask & ~w_pick;
              end
            end else begin
              addr_err <= 1'b1;
              r_state  <= S_WAIT_STOP;
            end
          end
          S_DATA: if (w_rise) begin
            r_data_sr <= w_byte[DATA_W-2:0];
            r_mask    <= r_mask & ~w_lose;
            lost      <= w_lose;
            if (r_cnt == '0) begin
              data_out   <= w_byte;
              data_valid <= 1'b1;
              r_state    <= S_DATA_ACK;
            end else begin
              r_cnt <= r_cnt - 1'b1;
            end
          end
          S_DATA_ACK: if (w_rise) begin
            r_cnt   <= CNT_W'(DATA_W - 1);
            r_state <= S_DATA;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: doc/i2c_multi_arb.md
I2C_MULTI_ARB -- requirements
Module: i2c_multi_arb

Interface
REQ-001 Parameter NUM_M, default 2: number of master channels (2..8).
REQ-002 Parameter ADDR_W, default 7: slave address width.
REQ-003 Parameter DATA_W, default 8: data byte width.
REQ-004 Parameter SLAVE_ADDR, default 7'b1010101: accepted slave address.
REQ-005 Parameter PRIO_MODE, default 0: tie resolution, 0 = fixed lowest index, 1 = round-robin.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 sda_in  in  NUM_M  per-master SDA drive, bit i = master i.
REQ-009 scl_in  in  NUM_M  per-master SCL drive.
REQ-010 scl, sda  out  1 each  arbitrated bus lines.
REQ-011 grant  out  NUM_M  contender mask (masters still owning the bus).
REQ-012 lost  out  NUM_M  one-cycle pulse per master dropped from contention.
REQ-013 busy  out  1  high from START to STOP.
REQ-014 addr_out  out  ADDR_W, rw_out  out  1  captured address and R/W bit.
REQ-015 data_out  out  DATA_W, data_valid  out  1  captured byte, one-cycle strobe.
REQ-016 addr_err, abort  out  1 each  one-cycle error pulses.

Function
REQ-017 Bus lines SHALL be combinational: scl = AND(scl_in | ~mask), sda = AND(sda_in | ~mask).
REQ-018 Bus scl/sda SHALL be registered once (scl_q, sda_q); rise = scl & ~scl_q; START = scl & scl_q & sda_q & ~sda; STOP = scl & scl_q & ~sda_q & sda.
REQ-019 States: IDLE, ADDR, ADDR_ACK, DATA, DATA_ACK, WAIT_STOP.
REQ-020 IDLE: mask = all ones; on START, mask <= ~sda_in, busy <= 1, bit counter <= ADDR_W, go to ADDR.
REQ-021 ADDR: on each rise, shift sda into {addr, rw}; counter decrements; at counter 0 go to ADDR_ACK.
REQ-022 Arbitration, ADDR and DATA only: on rise, any masked master with sda_in = 1 while sda = 0 SHALL be cleared from mask and pulse lost in the next cycle.
REQ-023 ADDR_ACK: ACK bit not arbitrated; on its rise, if addr == SLAVE_ADDR, publish addr_out/rw_out, counter <= DATA_W-1, go to DATA; otherwise pulse addr_err and go to WAIT_STOP.
REQ-024 Tie: on entering DATA with >1 bit set in mask, keep one master (PRIO_MODE 0: lowest index; PRIO_MODE 1: first set index above last winner, wrapping) and pulse lost for the rest.
REQ-025 Last winner register SHALL update at each STOP to the single mask bit; reset value index NUM_M-1 so first round-robin winner is master 0.
REQ-026 DATA: shift sda on rise; after DATA_W bits, data_out <= byte, data_valid pulses one cycle, go to DATA_ACK.
REQ-027 DATA_ACK: on rise, counter reloads, return to DATA (multi-byte transfers unbounded).
REQ-028 STOP in any non-IDLE state SHALL go to IDLE, busy <= 0, mask <= all ones, same cycle.
REQ-029 STOP with a partial byte (DATA counter not reloaded, or in ADDR) SHALL pulse abort and suppress data_valid.
REQ-030 START in any non-IDLE state (repeated start) SHALL restart ADDR with current mask retained.
REQ-031 WAIT_STOP: ignore all edges except STOP.
REQ-032 lost, data_valid, addr_err, abort SHALL never be high two consecutive cycles.

Reset
REQ-033 While reset = 0: state IDLE, mask all ones, busy 0, grant all ones, lost 0, addr_out 0, rw_out 0, data_out 0, data_valid 0, addr_err 0, abort 0, scl_q/sda_q 1; assertion mid-transfer takes effect immediately without pulses.

Verification (NUM_M = 2)
REQ-034 M0 START, addr 0x55 W, byte 0xA3, STOP; M1 held high -> grant 01, addr_out 0x55, rw_out 0, data_out 0xA3 with one data_valid, busy 0 after STOP.
REQ-035 M0 sends 0x55, M1 sends 0x54 -> at final address bit lost = 01 one cycle, grant 10, addr_err pulse, WAIT_STOP.
REQ-036 Both send 0x55 W, PRIO_MODE 0 -> entering DATA grant 01, lost 10; PRIO_MODE 1, second identical transaction -> grant 10.
REQ-037 Addr 0x33 -> addr_err pulse, no data_valid, busy held until STOP.
REQ-038 STOP after 3 data bits -> abort pulse, no data_valid, state IDLE, grant 11.
REQ-039 reset low mid-DATA -> all outputs at REQ-033 values within the same cycle; next START arbitrates normally.
